// File: rtl/shift_seq_unit.sv
// -----------------------------------------------------------------------------
// shift_seq_unit
//   Power-of-two multiply/divide engine. A value is loaded with L, then a
//   start command runs a programmable number of single-bit shifts, one per
//   clock, in one of four modes. Sequences with amt >= n are legal: SHL/SHR
//   saturate to zero, SAR saturates to all-sign and ROL wraps.
//
// Parameters
//   n   data width in bits (n >= 2)
//   SW  width of the shift-amount input
//
// Ports
//   clk    in   clock, all state updates on the rising edge
//   rst    in   synchronous active-high reset, overrides every other input
//   R      in   [n-1:0]  value to load
//   L      in   load strobe; aborts a running sequence without a done pulse
//   start  in   begin a sequence (accepted only when idle and L is low)
//   amt    in   [SW-1:0] number of single-bit shifts
//   mode   in   [1:0] 00 SHL, 01 SHR logical, 10 SAR arithmetic, 11 ROL
//   res    out  [n-1:0]  current register value
//   busy   out  high while a sequence is running
//   done   out  one-cycle pulse after the final shift (or after start, amt=0)
//   lost   out  sticky: a 1 bit was shifted out in the current/last sequence
// -----------------------------------------------------------------------------
module shift_seq_unit #(
  parameter int n  = 8,
  parameter int SW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [n-1:0]  R,
  input  logic          L,
  input  logic          start,
  input  logic [SW-1:0] amt,
  input  logic [1:0]    mode,
  output logic [n-1:0]  res,
  output logic          busy,
  output logic          done,
  output logic          lost
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    MODE_SHL = 2'b00,
    MODE_SHR = 2'b01,
    MODE_SAR = 2'b10,
    MODE_ROL = 2'b11
  } mode_t;

  state_t        state_q, state_d;
  mode_t         mode_q;
  logic [SW-1:0] count_q;

  logic          accept;     // start taken this edge
  logic          step;       // one shift performed this edge
  logic          last_step;  // this shift is the final one of the sequence
  logic [n-1:0]  shift_val;
  logic          shift_out;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A load always returns to IDLE, which is how a running
  // sequence gets aborted.
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven from always_comb receives a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (L) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start && (amt != '0)) state_d = RUN;
        RUN:     if (last_step)            state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == RUN);
    accept    = !L && (state_q == IDLE) && start;
    step      = !L && (state_q == RUN);
    last_step = (count_q == SW'(1));
  end

  // ---------------------------------------------------------------------------
  // One shift step in the latched mode. Pure bit moves, nothing wider than n.
  // ---------------------------------------------------------------------------
  always_comb begin
    shift_val = res;
    shift_out = 1'b0;
    case (mode_q)
      MODE_SHL: begin
        shift_val = {res[n-2:0], 1'b0};
        shift_out = res[n-1];
      end
      MODE_SHR: begin
        shift_val = {1'b0, res[n-1:1]};
        shift_out = res[0];
      end
      MODE_SAR: begin
        shift_val = {res[n-1], res[n-1:1]};
        shift_out = res[0];
      end
      MODE_ROL: begin
        // Rotation never loses information, so lost is untouched.
        shift_val = {res[n-2:0], res[n-1]};
        shift_out = 1'b0;
      end
      default: begin
        shift_val = res;
        shift_out = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: value, sticky lost flag, done pulse, latched mode and count.
  // mode/amt are captured at start so later changes on the inputs are ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      res     <= '0;
      lost    <= 1'b0;
      done    <= 1'b0;
      count_q <= '0;
      mode_q  <= MODE_SHL;
    end else if (L) begin
      res     <= R;
      lost    <= 1'b0;
      done    <= 1'b0;
      count_q <= '0;
    end else if (accept) begin
      mode_q  <= mode_t'(mode);
      count_q <= amt;
      lost    <= 1'b0;
      // A zero-length sequence completes immediately without entering RUN.
      done    <= (amt == '0);
    end else if (step) begin
      res     <= shift_val;
      lost    <= lost | shift_out;
      count_q <= count_q - SW'(1);
      done    <= last_step;
    end else begin
      done    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_unit
//   Self-checking bench for shift_seq_unit. A behavioural model computes the
//   expected value of every output each cycle: the result after j steps of a
//   sequence is derived in closed form from the value at start, and lost is
//   derived from which original bits have left the register. Directed
//   scenarios add literal expectations, then randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_shift_seq_unit;

  localparam int N  = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  R;
  logic          L;
  logic          start;
  logic [SW-1:0] amt;
  logic [1:0]    mode;
  logic [N-1:0]  res;
  logic          busy;
  logic          done;
  logic          lost;

  shift_seq_unit #(.n(N), .SW(SW)) dut (
    .clk   (clk),
    .rst   (rst),
    .R     (R),
    .L     (L),
    .start (start),
    .amt   (amt),
    .mode  (mode),
    .res   (res),
    .busy  (busy),
    .done  (done),
    .lost  (lost)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  // Value after j steps of mode md starting from b.
  function automatic logic [N-1:0] m_val(input logic [N-1:0] b, input logic [1:0] md,
                                         input int j);
    logic [N-1:0] v;
    int r;
    case (md)
      2'd0:    v = (j >= N) ? '0 : (b << j);
      2'd1:    v = (j >= N) ? '0 : (b >> j);
      2'd2:    v = $signed(b) >>> ((j >= N) ? (N - 1) : j);
      default: begin
        r = j % N;
        v = (b << r) | (b >> (N - r));
      end
    endcase
    return v;
  endfunction

  // Whether any 1 bit has left the register after j steps from b.
  function automatic logic m_lost_fn(input logic [N-1:0] b, input logic [1:0] md,
                                     input int j);
    int i;
    logic [31:0] w;
    i = (j > N) ? N : j;
    w = 32'(b);
    case (md)
      2'd0:       return (w >> (N - i)) != 0;
      2'd1, 2'd2: return (w & ((32'd1 << i) - 32'd1)) != 0;
      default:    return 1'b0;
    endcase
  endfunction

  logic [N-1:0] m_res   = '0;
  logic [N-1:0] m_base  = '0;
  logic [1:0]   m_mode  = '0;
  int           m_k     = 0;
  int           m_j     = 0;
  bit           m_run   = 1'b0;
  bit           m_done  = 1'b0;
  bit           m_lost  = 1'b0;
  bit           m_valid = 1'b0;

  // Inputs change only at negedges, so they are stable when sampled here.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_res = '0; m_run = 0; m_done = 0; m_lost = 0; m_valid = 1;
      end else if (L) begin
        m_res = R; m_lost = 0; m_done = 0; m_run = 0;
      end else if (!m_run && start) begin
        m_base = m_res; m_mode = mode; m_k = int'(amt); m_j = 0;
        m_lost = 0; m_done = (m_k == 0); m_run = (m_k != 0);
      end else if (m_run) begin
        m_j++;
        m_res  = m_val(m_base, m_mode, m_j);
        m_lost = m_lost_fn(m_base, m_mode, m_j);
        m_done = (m_j == m_k);
        m_run  = !m_done;
      end else begin
        m_done = 0;
      end
      #1;
      if (m_valid) begin
        check("res",  32'(res),  32'(m_res));
        check("busy", 32'(busy), 32'(m_run));
        check("done", 32'(done), 32'(m_done));
        check("lost", 32'(lost), 32'(m_lost));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all drive right after a negedge)
  // ---------------------------------------------------------------------------
  logic [N-1:0] trace[$];

  task automatic do_load(input logic [N-1:0] v);
    L = 1'b1; R = v;
    @(negedge clk);
    L = 1'b0;
  endtask

  // Starts a sequence, scrambles mode/amt afterwards (they must be ignored),
  // records res each cycle until done, counts busy cycles.
  task automatic run_seq(input logic [1:0] m, input int a, output int bc, output bit gd);
    start = 1'b1; mode = m; amt = SW'(a);
    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); amt = SW'($urandom);
    bc = 0; gd = 1'b0;
    trace.delete();
    for (int i = 0; i < 64; i++) begin
      trace.push_back(res);
      if (done) begin
        gd = 1'b1;
        break;
      end
      if (busy) bc++;
      @(negedge clk);
    end
    check("seq_done_seen", 32'(gd), 32'd1);
  endtask

  int bc;
  bit gd;

  initial begin
    rst = 1'b1; L = 1'b0; start = 1'b0; R = '0; amt = '0; mode = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset after arbitrary state, mid-sequence with lost already set.
    do_load(8'hFF);
    start = 1'b1; mode = 2'd0; amt = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t1_res",  32'(res),  32'h00);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_lost", 32'(lost), 32'd0);
    repeat (3) @(negedge clk);

    // SHL 3 from 0x03, then SHL 6 from 0x18.
    do_load(8'h03);
    run_seq(2'd0, 3, bc, gd);
    check("t2_busy_cycles", 32'(bc), 32'd3);
    check("t2_step1", 32'(trace[1]), 32'h06);
    check("t2_step2", 32'(trace[2]), 32'h0C);
    check("t2_step3", 32'(trace[3]), 32'h18);
    check("t2_lost",  32'(lost), 32'd0);
    run_seq(2'd0, 6, bc, gd);
    check("t2b_res",  32'(res),  32'h00);
    check("t2b_lost", 32'(lost), 32'd1);
    check("t2b_busy_cycles", 32'(bc), 32'd6);

    // SAR 2 from 0x90, then SHR 3.
    do_load(8'h90);
    run_seq(2'd2, 2, bc, gd);
    check("t3_sar_res",  32'(res),  32'hE4);
    check("t3_sar_lost", 32'(lost), 32'd0);
    run_seq(2'd1, 3, bc, gd);
    check("t3_shr_res",  32'(res),  32'h1C);
    check("t3_shr_lost", 32'(lost), 32'd1);

    // ROL 9 wraps to a rotate by 1; amt=0 completes at once.
    do_load(8'h81);
    run_seq(2'd3, 9, bc, gd);
    check("t4_busy_cycles", 32'(bc), 32'd9);
    check("t4_res",  32'(res),  32'h03);
    check("t4_lost", 32'(lost), 32'd0);
    run_seq(2'd3, 0, bc, gd);
    check("t4_zero_busy", 32'(bc),  32'd0);
    check("t4_zero_res",  32'(res), 32'h03);
    @(negedge clk);
    check("t4_done_once", 32'(done), 32'd0);

    // Load aborts a running sequence on its 2nd busy cycle.
    start = 1'b1; mode = 2'd0; amt = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    L = 1'b1; R = 8'h55;
    @(negedge clk);
    L = 1'b0;
    check("t5_res",  32'(res),  32'h55);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_lost", 32'(lost), 32'd0);
    repeat (8) @(negedge clk);

    // A second start while busy is ignored.
    start = 1'b1; mode = 2'd0; amt = 4'd2;
    @(negedge clk);
    start = 1'b1; mode = 2'd1; amt = 4'd7;
    @(negedge clk);
    start = 1'b0;
    check("t5b_busy_mid", 32'(busy), 32'd1);
    @(negedge clk);
    check("t5b_done", 32'(done), 32'd1);
    check("t5b_res",  32'(res),  32'h54);
    check("t5b_lost", 32'(lost), 32'd1);
    @(negedge clk);
    check("t5b_busy_after", 32'(busy), 32'd0);

    // Load wins over start on the same edge.
    L = 1'b1; R = 8'hA5; start = 1'b1; mode = 2'd0; amt = 4'd3;
    @(negedge clk);
    L = 1'b0; start = 1'b0;
    check("t6_res",  32'(res),  32'hA5);
    check("t6_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("t6_res_hold", 32'(res), 32'hA5);

    // Reset mid-RUN.
    start = 1'b1; mode = 2'd3; amt = 4'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6b_res",  32'(res),  32'h00);
    check("t6b_busy", 32'(busy), 32'd0);
    check("t6b_done", 32'(done), 32'd0);
    check("t6b_lost", 32'(lost), 32'd0);
    repeat (8) @(negedge clk);

    // Randomized traffic, checked every cycle against the model.
    repeat (3000) begin
      rst   = ($urandom_range(0, 99) < 2);
      L     = ($urandom_range(0, 15) == 0);
      start = ($urandom_range(0, 3) == 0);
      R     = N'($urandom);
      amt   = SW'($urandom);
      mode  = 2'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; L = 1'b0; start = 1'b0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
